pc_unit: RTL

- Program-counter stage directly downstream of the ALU zero detector in the single-cycle MIPS datapath.
- Consumes the 32-bit zero-detector output (bit 0 = "ALU result is zero"). Resolves beq/bne, j/jal and jr.
- Holds the architectural PC register, a retired-instruction counter and a misaligned-jr fault capture (EPC).
- Feeds instruction memory address and the jal link value back to the register file.

---
 rtl/pc_unit_pkg.sv | 23 ++
 rtl/pc_unit_if.sv | 33 +++
 rtl/pc_unit_next_pc_sel.sv | 28 ++
 rtl/pc_unit.sv | 90 +++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter stage: reset/exception vectors,
// next-PC select encoding and branch offset formation.
package pc_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

    typedef enum logic [2:0] {
        NPC_SEQ = 3'd0,
        NPC_BR  = 3'd1,
        NPC_J   = 3'd2,
        NPC_JR  = 3'd3,
        NPC_EXC = 3'd4
    } npc_sel_e;

    // Word offset to byte offset, sign preserved.
    function automatic logic signed [31:0] branch_offset(input logic [15:0] imm16);
        logic signed [31:0] ext;
        ext = {{16{imm16[15]}}, imm16};
        return ext <<< 2;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Datapath-facing bundle of the PC stage: control/operand inputs and PC outputs.
interface pc_unit_if;

    logic        stall;
    logic        branch;
    logic        branch_ne;
    logic [31:0] zero_in;
    logic [15:0] imm16;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] rs_value;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] link_addr;
    logic        taken;
    logic        fault;
    logic [31:0] epc;
    logic [31:0] retired;

    modport master (
        output stall, branch, branch_ne, zero_in, imm16, jump, jump_target,
               jump_reg, rs_value,
        input  pc, pc_plus4, link_addr, taken, fault, epc, retired
    );

    modport slave (
        input  stall, branch, branch_ne, zero_in, imm16, jump, jump_target,
               jump_reg, rs_value,
        output pc, pc_plus4, link_addr, taken, fault, epc, retired
    );

endinterface

// File: rtl/pc_unit_next_pc_sel.sv
// Priority and condition logic choosing the next-PC source: jr > j > taken branch > sequential.
module pc_unit_next_pc_sel
    import pc_unit_pkg::*;
(
    input  logic       branch,
    input  logic       branch_ne,
    input  logic       zero,
    input  logic       jump,
    input  logic       jump_reg,
    input  logic [1:0] rs_low,
    output npc_sel_e   sel,
    output logic       taken
);

    always_comb begin
        sel = NPC_SEQ;
        if (jump_reg) begin
            sel = (rs_low != 2'b00) ? NPC_EXC : NPC_JR;
        end else if (jump) begin
            sel = NPC_J;
        end else if (branch && (zero ^ branch_ne)) begin
            // beq takes on zero, bne on non-zero
            sel = NPC_BR;
        end
        taken = (sel != NPC_SEQ);
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, target formation, misaligned-jr capture
// and retired-instruction counter.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    pc_unit_if.slave     bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        fault_q, fault_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] npc;
    npc_sel_e    sel;
    logic        taken;
    logic        unused_zero_hi;

    // Only the zero flag in bit 0 is meaningful.
    assign unused_zero_hi = ^bus.zero_in[31:1];

    pc_unit_next_pc_sel u_sel (
        .branch    (bus.branch),
        .branch_ne (bus.branch_ne),
        .zero      (bus.zero_in[0]),
        .jump      (bus.jump),
        .jump_reg  (bus.jump_reg),
        .rs_low    (bus.rs_value[1:0]),
        .sel       (sel),
        .taken     (taken)
    );

    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        br_target = pc_plus4 + 32'(branch_offset(bus.imm16));
        j_target  = {pc_plus4[31:28], bus.jump_target, 2'b00};

        case (sel)
            NPC_BR:  npc = br_target;
            NPC_J:   npc = j_target;
            NPC_JR:  npc = bus.rs_value;
            NPC_EXC: npc = EXC_PC;
            default: npc = pc_plus4;
        endcase

        pc_d      = pc_q;
        epc_d     = epc_q;
        fault_d   = 1'b0;
        retired_d = retired_q;
        if (!bus.stall) begin
            pc_d      = npc;
            retired_d = retired_q + 32'd1;
            if (sel == NPC_EXC) begin
                epc_d   = pc_q;
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.link_addr = pc_plus4;
    assign bus.taken     = taken;
    assign bus.fault     = fault_q;
    assign bus.epc       = epc_q;
    assign bus.retired   = retired_q;

endmodule
